// File: rtl/prd_pkg.sv
// rtl/prd_pkg.sv - shared defaults for the PRD/PRM command input stages
package prd_pkg;

  localparam int PRD_CLOCK_IN  = 2_000_000;
  localparam int PRD_CH        = 16;
  localparam int PRD_TICK_FREQ = 10_000;
  localparam int PRD_CNT_MAX   = 15;
  localparam int PRD_ON_TH     = 10;
  localparam int PRD_OFF_TH    = 5;

  function automatic bit prd_th_ok(input int cnt_max, input int on_th, input int off_th);
    return (off_th >= 0) && (off_th < on_th) && (on_th <= cnt_max);
  endfunction

endpackage

// File: rtl/prd_debounce_ch.sv
// rtl/prd_debounce_ch.sv - one command channel: 2-FF sync, saturating integrator, hysteresis
module prd_debounce_ch
  import prd_pkg::*;
#(
  parameter int CNT_MAX = PRD_CNT_MAX,
  parameter int ON_TH   = PRD_ON_TH,
  parameter int OFF_TH  = PRD_OFF_TH
) (
  input  logic clk,
  input  logic aclr,
  input  logic tick,
  input  logic blk,
  input  logic raw,
  output logic com
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
  localparam logic [CW-1:0] ON_LVL  = CW'(ON_TH);
  localparam logic [CW-1:0] OFF_LVL = CW'(OFF_TH);

  logic          raw_s1;
  logic          raw_s2;
  logic          act;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          com_next;

  // Idle level of the opto lines is high, so the synchroniser resets to inactive.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      raw_s1 <= 1'b1;
      raw_s2 <= 1'b1;
    end else begin
      raw_s1 <= raw;
      raw_s2 <= raw_s1;
    end
  end

  assign act = ~raw_s2;

  // Blocking wins over the tick so the channel is held cleared on every clock.
  always_comb begin
    cnt_next = cnt;
    com_next = com;
    if (blk) begin
      cnt_next = '0;
      com_next = 1'b0;
    end else if (tick) begin
      if (act && (cnt < CNT_TOP)) begin
        cnt_next = cnt + 1'b1;
      end else if (!act && (cnt != '0)) begin
        cnt_next = cnt - 1'b1;
      end
      if (cnt_next >= ON_LVL) begin
        com_next = 1'b1;
      end else if (cnt_next <= OFF_LVL) begin
        com_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      cnt <= '0;
      com <= 1'b0;
    end else begin
      cnt <= cnt_next;
      com <= com_next;
    end
  end

endmodule

// File: rtl/prd_com_filter.sv
// rtl/prd_com_filter.sv - PRD command input stage: debounced, blockable commands with change report
module prd_com_filter
  import prd_pkg::*;
#(
  parameter int CLOCK_IN  = PRD_CLOCK_IN,
  parameter int TICK_FREQ = PRD_TICK_FREQ,
  parameter int CNT_MAX   = PRD_CNT_MAX,
  parameter int ON_TH     = PRD_ON_TH,
  parameter int OFF_TH    = PRD_OFF_TH,
  parameter int CH        = PRD_CH
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic [CH-1:0] iRaw,
  input  logic          iBl,
  output logic [CH-1:0] oCom,
  output logic          oChange,
  output logic [CH-1:0] oChangeMask
);

  localparam int DIV = CLOCK_IN / TICK_FREQ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  if (!prd_th_ok(CNT_MAX, ON_TH, OFF_TH)) begin : g_bad_threshold
    $error("prd_com_filter: thresholds must satisfy 0 <= OFF_TH < ON_TH <= CNT_MAX");
  end

  if ((CLOCK_IN % TICK_FREQ) != 0) begin : g_bad_divider
    $error("prd_com_filter: CLOCK_IN must be a multiple of TICK_FREQ");
  end

  logic [PW-1:0] pre;
  logic          tick;
  logic          bl_s1;
  logic          bl_s2;
  logic          blk;
  logic [CH-1:0] com_d;

  assign tick = (pre == PRE_LAST);

  // The prescaler is never blocked, keeping the tick grid steady across iBl.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      bl_s1 <= 1'b1;
      bl_s2 <= 1'b1;
    end else begin
      bl_s1 <= iBl;
      bl_s2 <= bl_s1;
    end
  end

  assign blk = ~bl_s2;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    prd_debounce_ch #(
      .CNT_MAX(CNT_MAX),
      .ON_TH  (ON_TH),
      .OFF_TH (OFF_TH)
    ) u_ch (
      .clk (clk),
      .aclr(aclr),
      .tick(tick),
      .blk (blk),
      .raw (iRaw[i]),
      .com (oCom[i])
    );
  end

  // com_d lags oCom by one clock; both clear together on aclr, so reset never strobes.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      com_d       <= '0;
      oChange     <= 1'b0;
      oChangeMask <= '0;
    end else begin
      com_d       <= oCom;
      oChange     <= (oCom != com_d);
      oChangeMask <= oCom ^ com_d;
    end
  end

endmodule

// File: tb/tb_prd_com_filter.sv
// tb/tb_prd_com_filter.sv - randomized self-checking bench for prd_com_filter
module tb_prd_com_filter;

  localparam int CH      = 16;
  localparam int DIV     = 200;
  localparam int CNT_MAX = 15;
  localparam int ON_TH   = 10;
  localparam int OFF_TH  = 5;

  logic          clk  = 1'b0;
  logic          aclr = 1'b1;
  logic [CH-1:0] iRaw = '1;
  logic          iBl  = 1'b1;
  logic [CH-1:0] oCom;
  logic          oChange;
  logic [CH-1:0] oChangeMask;

  int errors = 0;
  int checks = 0;

  // Reference model: per-channel counts in plain integers, stepped once per clock.
  int            m_cnt [CH];
  int            m_pre;
  logic [CH-1:0] m_com;
  logic [CH-1:0] m_prev_com;
  logic [CH-1:0] m_mask;
  logic          m_chg;
  logic [CH-1:0] m_raw_q [2];
  logic          m_bl_q  [2];

  prd_com_filter dut (
    .clk        (clk),
    .aclr       (aclr),
    .iRaw       (iRaw),
    .iBl        (iBl),
    .oCom       (oCom),
    .oChange    (oChange),
    .oChangeMask(oChangeMask)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    m_pre      = 0;
    m_com      = '0;
    m_prev_com = '0;
    m_mask     = '0;
    m_chg      = 1'b0;
    m_raw_q[0] = '1;
    m_raw_q[1] = '1;
    m_bl_q[0]  = 1'b1;
    m_bl_q[1]  = 1'b1;
  endtask

  task automatic model_update();
    bit tick_now;
    if (aclr) begin
      model_reset();
    end else begin
      tick_now   = (m_pre == DIV - 1);
      m_chg      = (m_com != m_prev_com);
      m_mask     = m_com ^ m_prev_com;
      m_prev_com = m_com;
      for (int i = 0; i < CH; i++) begin
        if (!m_bl_q[1]) begin
          m_cnt[i] = 0;
          m_com[i] = 1'b0;
        end else if (tick_now) begin
          if (!m_raw_q[1][i]) m_cnt[i] = (m_cnt[i] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[i] + 1;
          else                m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
          if (m_cnt[i] >= ON_TH)       m_com[i] = 1'b1;
          else if (m_cnt[i] <= OFF_TH) m_com[i] = 1'b0;
        end
      end
      m_pre      = (m_pre + 1) % DIV;
      m_raw_q[1] = m_raw_q[0];
      m_raw_q[0] = iRaw;
      m_bl_q[1]  = m_bl_q[0];
      m_bl_q[0]  = iBl;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [CH-1:0] raw);
    @(negedge clk);
    aclr = 1'b1;
    iRaw = raw;
    iBl  = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    aclr = 1'b0;
  endtask

  task automatic test_reset();
    int n_chg = 0;
    aclr = 1'b1;
    iRaw = '1;
    iBl  = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({oCom, oChange, oChangeMask} !== 33'd0)
      begin errors++; $display("FAIL reset_state: got com=%h chg=%b mask=%h, expected all 0", oCom, oChange, oChangeMask); end
    aclr = 1'b0;
    iRaw = 16'hFFF7;
    for (int cyc = 1; cyc <= 2300; cyc++) begin
      advance();
      checks++;
      if ({oCom, oChange, oChangeMask} !== {m_com, m_chg, m_mask})
        begin errors++; $display("FAIL reset_model t=%0t: got com=%h chg=%b mask=%h, expected com=%h chg=%b mask=%h", $time, oCom, oChange, oChangeMask, m_com, m_chg, m_mask); end
    end
    checks++;
    if (oCom !== 16'h0008) begin errors++; $display("FAIL pre_reset_com: got %h expected 0008", oCom); end
    #2 aclr = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({oCom, oChange, oChangeMask} !== 33'd0)
      begin errors++; $display("FAIL reset_async: got com=%h chg=%b mask=%h, expected all 0", oCom, oChange, oChangeMask); end
    @(negedge clk);
    @(negedge clk);
    aclr = 1'b0;
    for (int cyc = 1; cyc <= 2100; cyc++) begin
      advance();
      checks++;
      if ({oCom, oChange, oChangeMask} !== {m_com, m_chg, m_mask})
        begin errors++; $display("FAIL restart_model t=%0t: got com=%h chg=%b mask=%h, expected com=%h chg=%b mask=%h", $time, oCom, oChange, oChangeMask, m_com, m_chg, m_mask); end
      if (oChange && cyc <= 2000) n_chg++;
      if (cyc == 1999 || cyc == 2000) begin
        checks++;
        if (oCom !== ((cyc == 2000) ? 16'h0008 : 16'h0000))
          begin errors++; $display("FAIL restart_tick cyc=%0d: got %h", cyc, oCom); end
      end
    end
    checks++;
    if (n_chg != 0) begin errors++; $display("FAIL no_reset_strobe: got %0d strobes expected 0", n_chg); end
  endtask

  task automatic test_single();
    int n_chg = 0;
    do_reset(16'hFFF7);
    for (int cyc = 1; cyc <= 5600; cyc++) begin
      advance();
      checks++;
      if ({oCom, oChange, oChangeMask} !== {m_com, m_chg, m_mask})
        begin errors++; $display("FAIL single_model t=%0t: got com=%h chg=%b mask=%h, expected com=%h chg=%b mask=%h", $time, oCom, oChange, oChangeMask, m_com, m_chg, m_mask); end
      if (oChange) n_chg++;
      if (cyc == 1999 || cyc == 2000 || cyc == 5399 || cyc == 5400) begin
        checks++;
        if (oCom !== ((cyc == 1999 || cyc == 5400) ? 16'h0000 : 16'h0008))
          begin errors++; $display("FAIL single_edge cyc=%0d: got %h", cyc, oCom); end
      end
      if (cyc == 2001 || cyc == 5401) begin
        checks++;
        if (oChange !== 1'b1 || oChangeMask !== 16'h0008)
          begin errors++; $display("FAIL single_strobe cyc=%0d: got chg=%b mask=%h expected 1/0008", cyc, oChange, oChangeMask); end
      end
      if (cyc == 3400) iRaw = 16'hFFFF;
    end
    checks++;
    if (n_chg != 2) begin errors++; $display("FAIL single_strobe_count: got %0d expected 2", n_chg); end
  endtask

  task automatic test_glitch();
    int n_chg = 0;
    int off;
    off = int'($urandom_range(0, 399));
    do_reset(16'hFFFF);
    for (int cyc = 1; cyc <= 8000; cyc++) begin
      advance();
      checks++;
      if ({oCom, oChange, oChangeMask} !== {m_com, m_chg, m_mask})
        begin errors++; $display("FAIL glitch_model t=%0t: got com=%h chg=%b mask=%h, expected com=%h chg=%b mask=%h", $time, oCom, oChange, oChangeMask, m_com, m_chg, m_mask); end
      if (oChange) n_chg++;
      iRaw = (((cyc + off) % 400) < 150) ? 16'hFFFE : 16'hFFFF;
    end
    checks++;
    if (n_chg != 0 || oCom !== 16'h0000)
      begin errors++; $display("FAIL glitch: got %0d strobes com=%h, expected 0 strobes com=0000", n_chg, oCom); end
  endtask

  task automatic test_simultaneous();
    int n_chg = 0;
    logic [CH-1:0] got_mask = '0;
    do_reset(16'hFFFF);
    repeat (int'($urandom_range(0, 199))) advance();
    iRaw = 16'h0F0F;
    for (int cyc = 1; cyc <= 2400; cyc++) begin
      advance();
      checks++;
      if ({oCom, oChange, oChangeMask} !== {m_com, m_chg, m_mask})
        begin errors++; $display("FAIL simul_model t=%0t: got com=%h chg=%b mask=%h, expected com=%h chg=%b mask=%h", $time, oCom, oChange, oChangeMask, m_com, m_chg, m_mask); end
      if (oChange) begin n_chg++; got_mask = oChangeMask; end
    end
    checks++;
    if (n_chg != 1 || got_mask !== 16'hF0F0 || oCom !== 16'hF0F0)
      begin errors++; $display("FAIL simultaneous: got %0d strobes mask=%h com=%h, expected 1 F0F0 F0F0", n_chg, got_mask, oCom); end
  endtask

  task automatic test_blocking();
    iRaw = 16'h0000;
    for (int cyc = 1; cyc <= 2400; cyc++) begin
      advance();
      checks++;
      if ({oCom, oChange, oChangeMask} !== {m_com, m_chg, m_mask})
        begin errors++; $display("FAIL block_model t=%0t: got com=%h chg=%b mask=%h, expected com=%h chg=%b mask=%h", $time, oCom, oChange, oChangeMask, m_com, m_chg, m_mask); end
    end
    checks++;
    if (oCom !== 16'hFFFF) begin errors++; $display("FAIL block_all_on: got %h expected FFFF", oCom); end
    iBl = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      advance();
      checks++;
      if ({oCom, oChange, oChangeMask} !== {m_com, m_chg, m_mask})
        begin errors++; $display("FAIL blocked_model t=%0t: got com=%h chg=%b mask=%h, expected com=%h chg=%b mask=%h", $time, oCom, oChange, oChangeMask, m_com, m_chg, m_mask); end
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if (oCom !== ((cyc == 3) ? 16'h0000 : 16'hFFFF))
          begin errors++; $display("FAIL block_latency cyc=%0d: got %h", cyc, oCom); end
      end
      if (cyc == 4) begin
        checks++;
        if (oChange !== 1'b1 || oChangeMask !== 16'hFFFF)
          begin errors++; $display("FAIL block_strobe: got chg=%b mask=%h expected 1/FFFF", oChange, oChangeMask); end
      end
    end
    iBl = 1'b1;
    for (int cyc = 1; cyc <= 2100; cyc++) begin
      advance();
      checks++;
      if ({oCom, oChange, oChangeMask} !== {m_com, m_chg, m_mask})
        begin errors++; $display("FAIL unblock_model t=%0t: got com=%h chg=%b mask=%h, expected com=%h chg=%b mask=%h", $time, oCom, oChange, oChangeMask, m_com, m_chg, m_mask); end
      if (cyc == 1800 || cyc == 2002) begin
        checks++;
        if (oCom !== ((cyc == 2002) ? 16'hFFFF : 16'h0000))
          begin errors++; $display("FAIL unblock_time cyc=%0d: got %h", cyc, oCom); end
      end
    end
  endtask

  task automatic test_hysteresis();
    int n_chg = 0;
    do_reset(16'hFFDF);
    for (int cyc = 1; cyc <= 3300; cyc++) begin
      advance();
      checks++;
      if ({oCom, oChange, oChangeMask} !== {m_com, m_chg, m_mask})
        begin errors++; $display("FAIL hyst_model t=%0t: got com=%h chg=%b mask=%h, expected com=%h chg=%b mask=%h", $time, oCom, oChange, oChangeMask, m_com, m_chg, m_mask); end
      if (oChange && cyc >= 2002) n_chg++;
      if (cyc == 2000 || cyc == 2600 || cyc == 3300) begin
        checks++;
        if (oCom !== 16'h0020) begin errors++; $display("FAIL hyst_hold cyc=%0d: got %h expected 0020", cyc, oCom); end
      end
      if (cyc == 2000) iRaw = 16'hFFFF;
      if (cyc == 2600) iRaw = 16'hFFDF;
    end
    checks++;
    if (n_chg != 0) begin errors++; $display("FAIL hyst_strobe: got %0d strobes expected 0", n_chg); end
  endtask

  task automatic test_random();
    int total = 0;
    int len;
    do_reset(16'hFFFF);
    while (total < 12000) begin
      len  = int'($urandom_range(100, 1200));
      iRaw = iRaw ^ 16'($urandom & $urandom);
      iBl  = ($urandom_range(0, 7) != 0);
      for (int cyc = 0; cyc < len; cyc++) begin
        advance();
        checks++;
        if ({oCom, oChange, oChangeMask} !== {m_com, m_chg, m_mask})
          begin errors++; $display("FAIL random_model t=%0t: got com=%h chg=%b mask=%h, expected com=%h chg=%b mask=%h", $time, oCom, oChange, oChangeMask, m_com, m_chg, m_mask); end
      end
      total += len;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_simultaneous();
    test_blocking();
    test_hysteresis();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
